cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
//  Successor to the fixed 16-bit combinational fast adder; it adds width and group-size parameters,
//  a subtract mode, status flags and an optional mid-pipeline register.
//  Sits in the integer execute path (ALU add/sub, branch compare, address generation).
// PARAMETERS
//  WIDTH   32  operand width; must be a multiple of BLOCK
//  BLOCK   4   bits per lookahead group (first level)
//  PIPE    2   register stages, 1 or 2 (latency in cycles); other values are rejected by elaboration
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand beat
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in; ignored when sub=1
//  sub        in   1      0: a+b+cin, 1: a+~b+1
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the result beat
//  sum        out  WIDTH  result
//  cout       out  1      carry out of the MSB (subtract: 1 = no borrow)
//  ovf        out  1      signed overflow, c[WIDTH-1]^c[WIDTH]
//  zero       out  1      sum == 0
//  gout,pout  out  1      whole-word group generate/propagate (pout = &(a ^ b_eff))
// BEHAVIOUR
//  - Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
//    Bit level: g = a & b_eff, p = a ^ b_eff; sum[i] = p[i] ^ c[i].
//  - Level 1: per BLOCK group, G/P and intra-group carries are computed in lookahead form (no ripple).
//    Level 2: group carry-ins come from a lookahead over the group G/P and c0.
//  - PIPE=2:
//      stage 1 registers p, g, the group G/P, c0 and the intra-group lookahead terms;
//      stage 2 registers sum and the flags.
//    PIPE=1: only the output register.
//  - Latency is PIPE cycles from the accepting edge to out_valid, with no stall.
//    Throughput is 1 beat/cycle.
//  - Handshake: a beat transfers when valid && ready on a rising edge.
//    Each stage k holds v_k; stage k loads when !v_k || (downstream takes it).
//    in_ready = !v_1 || advance_1 (combinational from out_ready); bubbles collapse.
//    While out_valid=1 && out_ready=0, the outputs and sum are held stable.
//  - Beats leave in issue order; no beat is dropped or duplicated.
//  - in_valid must not drop without a transfer. a, b, cin and sub must stay stable while in_valid && !in_ready.
//  - Reset (async assert, sync deassert upstream): all v_k=0; out_valid=0; sum, cout, ovf, gout, pout = 0; zero=0.
//    in_ready=1 from the first cycle after reset.
//  - Reset mid-operation discards all in-flight beats; there is no partial output.
//  - Boundaries:
//      all-ones + 1 wraps to 0 (cout=1, zero=1).
//      cin=1 with p all ones: the carry propagates the full word (pout=1, gout=0, cout=1).
//      sub with a==b: sum=0, cout=1, zero=1, ovf=0.
//  - Fully synchronous datapath; no X on outputs after reset.
// STRUCTURE
//  - Shared package cla_pkg:
//      function cla_carries(g, p, cin) returning a BLOCK-wide carry vector plus group G/P;
//      localparam NGRP = WIDTH/BLOCK;
//      typedef stage1_t (p, g, G, P, c0).
//  - One sub-module: cla_group (BLOCK-bit lookahead group: inputs g, p, ci; outputs carries, G, P).
//    It is instantiated NGRP times for level 1 and once, with BLOCK=NGRP, for level 2 when NGRP<=8.
//  - Top level holds the operand prep, the valid/ready stage registers and the flags.
// TESTING  (WIDTH=32, BLOCK=4, PIPE=2 unless noted)
//  1 a=FFFFFFFF b=00000001 cin=0 sub=0 -> sum=00000000 cout=1 zero=1 ovf=0, out_valid exactly 2 cycles after accept.
//  2 a=7FFFFFFF b=00000001 sub=0 -> sum=80000000 ovf=1 cout=0;
//    a=00000005 b=00000007 sub=1 -> sum=FFFFFFFE cout=0 ovf=0.
//  3 a=FFFF0000 b=0000FFFF cin=1 -> sum=00000000 cout=1 pout=1 gout=0 (full-length propagate).
//  4 Issue 4 back-to-back beats, out_ready=0 for 5 cycles:
//    in_ready drops after 2 beats are buffered; on release all 4 emerge in order; sum is stable while stalled.
//  5 Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately;
//    after release there is no stale beat and in_ready=1.
//  6 Random a/b/cin/sub against a reference model with random stalls, 10^5 beats, for PIPE=1 and 2,
//    WIDTH=16/BLOCK=4 and WIDTH=64/BLOCK=8 -> zero mismatches.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared lookahead helpers for the pipelined CLA adder: default geometry and the
// carry/group-generate/group-propagate function used by every lookahead group.
package cla_pkg;

   localparam int CLA_WIDTH = 32;
   localparam int CLA_BLOCK = 4;
   localparam int NGRP      = CLA_WIDTH / CLA_BLOCK;
   localparam int MAXB      = 16;

   typedef struct packed {
      logic [MAXB-1:0] c;
      logic            gen;
      logic            prop;
   } cla_res_t;

   // c[i] is the carry into bit i, each written as a flat sum of products.
   function automatic cla_res_t cla_carries(input logic [MAXB-1:0] g,
                                            input logic [MAXB-1:0] p,
                                            input logic            cin);
      cla_res_t r;
      logic     gsum;
      logic     pprod;
      logic     term;
      r      = '0;
      r.c[0] = cin;
      for (int i = 0; i < MAXB; i++) begin
         gsum  = 1'b0;
         pprod = 1'b1;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            gsum  = gsum | term;
            pprod = pprod & p[j];
         end
         if (i < MAXB - 1) r.c[i+1] = gsum | (pprod & cin);
         r.gen  = gsum;
         r.prop = pprod;
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_group.sv
// BLOCK-bit carry-lookahead group: carries into each bit plus group G/P.
// Purely combinational; no handshake.
module cla_group
   import cla_pkg::*;
#(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] g,
   input  logic [BLOCK-1:0] p,
   input  logic             ci,
   output logic [BLOCK-1:0] c,
   output logic             gen,
   output logic             prop
);

   logic [MAXB-1:0] g_pad;
   logic [MAXB-1:0] p_pad;
   cla_res_t        r;

   // Live bits sit at the top; the padding below is pure propagate, so it passes ci through.
   always_comb begin
      g_pad                    = '0;
      p_pad                    = '1;
      g_pad[MAXB-1 -: BLOCK]   = g;
      p_pad[MAXB-1 -: BLOCK]   = p;
   end

   assign r = cla_carries(g_pad, p_pad, ci);

   // Every carry at or below the first live bit equals ci, so the AND is just that carry.
   always_comb begin
      c    = r.c[MAXB-1 -: BLOCK];
      c[0] = &r.c[MAXB-BLOCK:0];
   end

   assign gen  = r.gen;
   assign prop = r.prop;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined two-level CLA add/sub with flags; PIPE cycles latency, 1 beat/cycle.
// Valid/ready per stage: bubbles collapse, outputs hold while out_ready is low.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int BLOCK = CLA_BLOCK,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             gout,
   output logic             pout
);

   localparam int NG = WIDTH / BLOCK;

   // cg/pp are each bit's in-group carry with group carry-in 0 and its in-group prefix propagate.
   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] cg;
      logic [WIDTH-1:0] pp;
      logic [NG-1:0]    G;
      logic [NG-1:0]    P;
      logic             c0;
   } stage1_t;

   generate
      if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
         $error("cla_adder_pipe: PIPE must be 1 or 2");
      end
      if (WIDTH % BLOCK != 0) begin : g_bad_block
         $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK");
      end
   endgenerate

   logic [WIDTH-1:0] b_eff, g, p, cg_w, pp_w;
   logic [NG-1:0]    grp_g, grp_p;
   logic             c0;
   stage1_t          s1_d, s1;
   logic             s1_vld, ld_out;

   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;
   assign g     = a & b_eff;
   assign p     = a ^ b_eff;

   for (genvar k = 0; k < NG; k++) begin : g_lvl1
      cla_group #(.BLOCK(BLOCK)) u_grp (
         .g    (g[k*BLOCK +: BLOCK]),
         .p    (p[k*BLOCK +: BLOCK]),
         .ci   (1'b0),
         .c    (cg_w[k*BLOCK +: BLOCK]),
         .gen  (grp_g[k]),
         .prop (grp_p[k])
      );
   end

   always_comb begin
      logic run;
      run  = 1'b1;
      pp_w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i % BLOCK == 0) run = 1'b1;
         pp_w[i] = run;
         run     = run & p[i];
      end
   end

   assign s1_d = '{p: p, cg: cg_w, pp: pp_w, G: grp_g, P: grp_p, c0: c0};
   assign ld_out = !out_valid || out_ready;

   generate
      if (PIPE == 2) begin : g_pipe2
         logic    v1;
         stage1_t s1_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1   <= 1'b0;
               s1_q <= '0;
            end else if (in_ready) begin
               v1 <= in_valid;
               if (in_valid) s1_q <= s1_d;
            end
         end
         assign s1       = s1_q;
         assign s1_vld   = v1;
         assign in_ready = !v1 || ld_out;
      end else begin : g_pipe1
         assign s1       = s1_d;
         assign s1_vld   = in_valid;
         assign in_ready = ld_out;
      end
   endgenerate

   logic [NG-1:0]    gc;
   logic             gw, pw;
   logic [WIDTH-1:0] c_bit, sum_d;
   logic             cout_d;

   generate
      if (NG <= 8) begin : g_lvl2
         cla_group #(.BLOCK(NG)) u_lvl2 (
            .g    (s1.G),
            .p    (s1.P),
            .ci   (s1.c0),
            .c    (gc),
            .gen  (gw),
            .prop (pw)
         );
      end else begin : g_lvl2_chain
         always_comb begin
            logic cy;
            cy = s1.c0;
            gw = 1'b0;
            pw = 1'b1;
            gc = '0;
            for (int k = 0; k < NG; k++) begin
               gc[k] = cy;
               cy    = s1.G[k] | (s1.P[k] & cy);
               gw    = s1.G[k] | (s1.P[k] & gw);
               pw    = pw & s1.P[k];
            end
         end
      end
   endgenerate

   always_comb begin
      c_bit = '0;
      for (int i = 0; i < WIDTH; i++) c_bit[i] = s1.cg[i] | (s1.pp[i] & gc[i / BLOCK]);
   end

   assign sum_d  = s1.p ^ c_bit;
   assign cout_d = gw | (pw & s1.c0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         gout      <= 1'b0;
         pout      <= 1'b0;
      end else if (ld_out) begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            sum  <= sum_d;
            cout <= cout_d;
            ovf  <= c_bit[WIDTH-1] ^ cout_d;
            zero <= (sum_d == '0);
            gout <= gw;
            pout <= pw;
         end
      end
   end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Randomised and directed bench for cla_adder_pipe against an arithmetic reference model.
module tb_cla_adder_pipe;

   localparam int WIDTH = 32;
   localparam int BLOCK = 4;
   localparam int PIPE  = 2;
   localparam int NRAND = 3000;

   typedef logic [WIDTH+4:0] res_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout, ovf, zero, gout, pout;

   int   total = 0;
   int   bad = 0;
   logic acc, dlv;
   res_t expq[$];
   res_t last_got;

   always #5 clk = ~clk;

   cla_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK), .PIPE(PIPE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .gout(gout), .pout(pout)
   );

   function automatic res_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                  input logic ci, input logic si);
      logic [WIDTH-1:0] be;
      logic [WIDTH:0]   full, gfull;
      logic             c0, sovf;
      be    = si ? ~bi : bi;
      c0    = si ? 1'b1 : ci;
      full  = {1'b0, ai} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
      gfull = {1'b0, ai} + {1'b0, be};
      sovf  = (ai[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ai[WIDTH-1]);
      return {full[WIDTH-1:0], full[WIDTH], sovf, full[WIDTH-1:0] == '0, gfull[WIDTH], &(ai ^ be)};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      res_t got;
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
         got      = {sum, cout, ovf, zero, gout, pout};
         last_got = got;
         check("queue_nonempty", expq.size() != 0, 1);
         if (expq.size() != 0) check("beat", got, expq.pop_front());
      end
      if (acc) expq.push_back(model(a, b, cin, sub));
      @(negedge clk);
   endtask

   task automatic one(input string tag, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                      input logic ci, input logic si, input logic [WIDTH-1:0] esum,
                      input logic ec, input logic eo, input logic ez, input logic eg, input logic ep);
      int n, lat;
      a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1; out_ready = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 50) begin step(); n++; end
      in_valid = 1'b0;
      check({tag, "_accept"}, acc, 1);
      lat = 0; dlv = 1'b0;
      while (!dlv && lat < 50) begin step(); lat++; end
      check({tag, "_latency"}, lat, PIPE);
      check({tag, "_sum"},  last_got[WIDTH+4:5], esum);
      check({tag, "_cout"}, last_got[4], ec);
      check({tag, "_ovf"},  last_got[3], eo);
      check({tag, "_zero"}, last_got[2], ez);
      check({tag, "_gout"}, last_got[1], eg);
      check({tag, "_pout"}, last_got[0], ep);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] sa[4], sb[4], held;
      logic             have;
      int               idx, n, ndl, issued, got_n;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {out_valid, sum, cout, ovf, zero, gout, pout}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      one("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1, 1, 0);
      one("sovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0, 0, 0);
      one("sub5m7",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
      one("fullprop",32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 1, 0, 1);
      one("subeq",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1, 0, 1, 0, 1);

      // Four back-to-back beats into a stalled consumer.
      for (int i = 0; i < 4; i++) begin sa[i] = $urandom; sb[i] = $urandom; end
      out_ready = 1'b0; idx = 0; have = 1'b0; held = '0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin a = sa[idx]; b = sb[idx]; cin = 1'b0; sub = idx[0]; end
         step();
         if (acc) idx++;
         if (out_valid) begin
            if (!have) begin held = sum; have = 1'b1; end
            else check("stall_hold", sum, held);
         end
      end
      check("stall_accepted", idx, 2);
      check("stall_in_ready", in_ready, 0);
      out_ready = 1'b1; n = 0; ndl = 0;
      while ((idx < 4 || expq.size() != 0) && n < 100) begin
         in_valid = (idx < 4);
         if (idx < 4) begin a = sa[idx]; b = sb[idx]; cin = 1'b0; sub = idx[0]; end
         step();
         if (acc) idx++;
         if (dlv) ndl++;
         n++;
      end
      in_valid = 1'b0;
      check("stall_drain", ndl, 4);

      // Reset with two beats in flight.
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
      step();
      a = $urandom;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_flush_valid", out_valid, 0);
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ndl = 0;
      for (int i = 0; i < 6; i++) begin step(); if (dlv) ndl++; end
      check("post_rst_stale", ndl, 0);
      check("post_rst_in_ready", in_ready, 1);

      // Random traffic with random consumer stalls.
      issued = 0; got_n = 0; n = 0;
      while ((issued < NRAND || expq.size() != 0) && n < 40000) begin
         if (!in_valid && issued < NRAND && $urandom_range(3) != 0) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            case ($urandom_range(7))
               0: b = a;
               1: a = '1;
               2: b = ~a;
               default: ;
            endcase
         end
         out_ready = ($urandom_range(9) < 7);
         step();
         if (acc) begin issued++; in_valid = 1'b0; end
         if (dlv) got_n++;
         n++;
      end
      in_valid = 1'b0;
      check("rand_count", got_n, NRAND);
      check("rand_leftover", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
